// File: rtl/alu_pkg.sv
// Shared opcode encodings and default widths for the switch-driven ALU.
// Optional SLL opcode is decoded only when ALU_SLL_EN is defined.
package alu_pkg;

  localparam int unsigned DEF_SWITCHES = 6;
  localparam int unsigned DEF_LEDS     = 6;
  localparam int unsigned DEF_BOTONES  = 4;
  localparam int unsigned OP_W         = 6;

  // Enable strobe bit positions on the button bus
  localparam int unsigned EN_A  = 0;
  localparam int unsigned EN_OP = 1;
  localparam int unsigned EN_B  = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 6'b000000,
    OP_SRL = 6'b000010,
    OP_SRA = 6'b000011,
    OP_ADD = 6'b100000,
    OP_SUB = 6'b100010,
    OP_AND = 6'b100100,
    OP_OR  = 6'b100101,
    OP_XOR = 6'b100110,
    OP_NOR = 6'b100111
  } op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result = f(op, a, b), zero for unknown opcodes.
// ALU_SLL_EN adds opcode 000000 as a logical left shift.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned W = DEF_SWITCHES
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] op,
  output logic [W-1:0] result
);

  // Shift amounts >= W fall out naturally: SV shifts fill with sign/zero bits.
  always_comb begin
    result = '0;
    case (op)
      W'(OP_ADD): result = W'(a + b);
      W'(OP_SUB): result = W'(a - b);
      W'(OP_AND): result = a & b;
      W'(OP_OR):  result = a | b;
      W'(OP_XOR): result = a ^ b;
      W'(OP_NOR): result = ~(a | b);
      W'(OP_SRA): result = W'($signed(a) >>> b);
      W'(OP_SRL): result = W'(a >> b);
`ifdef ALU_SLL_EN
      W'(OP_SLL): result = W'(a << b);
`endif
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Switch-loaded ALU: A, OP and B are captured from a shared switch bus by
// level-sensitive enables; the result is registered onto the LEDs.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned CANT_SWITCHES = DEF_SWITCHES,
  parameter int unsigned CANT_LEDS     = DEF_LEDS,
  parameter int unsigned CANT_BOTONES  = DEF_BOTONES
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [CANT_SWITCHES-1:0] i_switch,
  input  logic [CANT_BOTONES-1:0]  i_enable,
  output logic [CANT_LEDS-1:0]     o_leds
);

  logic [CANT_SWITCHES-1:0] a;
  logic [CANT_SWITCHES-1:0] b;
  logic [CANT_SWITCHES-1:0] op;
  logic [CANT_SWITCHES-1:0] result;

  // Buttons from bit 3 upward carry no function
  logic unused_enable;
  assign unused_enable = ^i_enable[CANT_BOTONES-1:3];

  // Operand/opcode registers; each enable loads independently from i_switch
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      a  <= '0;
      op <= '0;
      b  <= '0;
    end else begin
      if (i_enable[EN_A])  a  <= i_switch;
      if (i_enable[EN_OP]) op <= i_switch;
      if (i_enable[EN_B])  b  <= i_switch;
    end
  end

  alu_core #(
    .W (CANT_SWITCHES)
  ) u_core (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result)
  );

  // Result register: one cycle behind the operand registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) o_leds <= '0;
    else          o_leds <= CANT_LEDS'(result);
  end

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for alu: opcode vectors plus reset,
// multi-enable, level-load and reserved-button sequences.
module tb_alu;

  localparam int unsigned W  = 6;
  localparam int unsigned NB = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  sw;
  logic [NB-1:0] en;
  logic [W-1:0]  leds;

  int n_checks = 0;
  int n_fail   = 0;

  alu #(
    .CANT_SWITCHES (W),
    .CANT_LEDS     (W),
    .CANT_BOTONES  (NB)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst_n),
    .i_switch (sw),
    .i_enable (en),
    .o_leds   (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] op;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: o_leds=%b expected %b", name, act, exp);
    end
  endtask

  // Hold the given enables high across exactly one rising edge
  task automatic load(input logic [NB-1:0] e, input logic [W-1:0] v);
    @(negedge clk);
    sw = v;
    en = e;
    @(negedge clk);
    en = '0;
  endtask

  task automatic run_vec(input vec_t v);
    load(4'b0001, v.a);
    load(4'b0010, v.op);
    load(4'b0100, v.b);
    @(negedge clk);
    check(v.name, leds, v.exp);
  endtask

  logic [W-1:0] sll_exp;

  initial begin
`ifdef ALU_SLL_EN
    sll_exp = 6'b010100;
`else
    sll_exp = 6'b000000;
`endif
    vecs[0]  = '{"add0",    6'b010101, 6'b100000, 6'b010101, 6'b101010};
    vecs[1]  = '{"add1",    6'b110101, 6'b100000, 6'b000101, 6'b111010};
    vecs[2]  = '{"sub",     6'b010101, 6'b100010, 6'b000101, 6'b010000};
    vecs[3]  = '{"and",     6'b110101, 6'b100100, 6'b000101, 6'b000101};
    vecs[4]  = '{"or",      6'b110101, 6'b100101, 6'b000101, 6'b110101};
    vecs[5]  = '{"xor",     6'b110101, 6'b100110, 6'b000101, 6'b110000};
    vecs[6]  = '{"nor",     6'b110101, 6'b100111, 6'b000101, 6'b001010};
    vecs[7]  = '{"sra",     6'b110101, 6'b000011, 6'b000011, 6'b111110};
    vecs[8]  = '{"srl",     6'b110101, 6'b000010, 6'b000011, 6'b000110};
    vecs[9]  = '{"bad_op",  6'b110101, 6'b111111, 6'b000101, 6'b000000};
    vecs[10] = '{"sll_op",  6'b000101, 6'b000000, 6'b000010, sll_exp};
    vecs[11] = '{"sra_big", 6'b110101, 6'b000011, 6'b000111, 6'b111111};
    vecs[12] = '{"srl_big", 6'b110101, 6'b000010, 6'b000110, 6'b000000};
    vecs[13] = '{"sub_wrap",6'b000001, 6'b100010, 6'b000010, 6'b111111};

    rst_n = 1'b0;
    sw    = '0;
    en    = '0;
    #12;
    check("reset_state", leds, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // All three enables at once load the same switch value (AND of equal values)
    load(4'b0111, 6'b100100);
    @(negedge clk);
    check("multi_enable", leds, 6'b100100);

    // Level-sensitive load: the last value sampled while high is kept
    load(4'b0010, 6'b100000);
    load(4'b0100, 6'b000001);
    @(negedge clk);
    sw = 6'b000011;
    en = 4'b0001;
    @(negedge clk);
    sw = 6'b000111;
    @(negedge clk);
    en = '0;
    sw = 6'b111111;
    @(negedge clk);
    check("level_load", leds, 6'b001000);

    // Reserved button: registers and output must not move
    run_vec(vecs[0]);
    @(negedge clk);
    sw = 6'b111111;
    en = 4'b1000;
    repeat (3) @(negedge clk);
    en = '0;
    check("en3_ignored", leds, 6'b101010);
    load(4'b0100, 6'b000001);
    @(negedge clk);
    check("en3_regs_kept", leds, 6'b010110);

    // Asynchronous reset mid-operation, with a load pending during reset
    run_vec(vecs[1]);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", leds, 6'b000000);
    sw = 6'b100100;
    en = 4'b0111;
    repeat (2) @(negedge clk);
    check("reset_hold", leds, 6'b000000);
    rst_n = 1'b1;
    en    = '0;
    repeat (2) @(negedge clk);
    check("post_reset_idle", leds, 6'b000000);

    // Loading resumes normally after reset
    run_vec(vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter CANT_SWITCHES, default 6, data width of operands, opcode and switch bus.
REQ-002 SHALL have parameter CANT_LEDS, default 6, result/LED width; SHALL equal CANT_SWITCHES.
REQ-003 SHALL have parameter CANT_BOTONES, default 4, number of enable buttons.
REQ-004 SHALL have port i_clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_switch  input  CANT_SWITCHES  shared data/opcode input.
REQ-007 SHALL have port i_enable  input  CANT_BOTONES  load strobes: bit0 = operand A, bit1 = opcode, bit2 = operand B, bit3 reserved and ignored.
REQ-008 SHALL have port o_leds  output  CANT_LEDS  registered ALU result.

Function
REQ-009 SHALL load A, OP and B from i_switch on every rising edge while i_enable[0], [1] and [2] respectively are high; level-sensitive, so the last value sampled while high is kept.
REQ-010 SHALL hold each register when its enable bit is low.
REQ-011 SHALL load every register whose enable bit is high when several bits are high in the same cycle, each from the same i_switch value.
REQ-012 SHALL decode OP as 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL.
REQ-013 SHALL compute ADD and SUB modulo 2^CANT_LEDS, discarding carry/borrow.
REQ-014 SHALL shift A right by the unsigned value of B for SRA (sign-filled) and SRL (zero-filled); a shift amount >= width SHALL give all sign bits (SRA) or zero (SRL).
REQ-015 SHALL output zero for any opcode not listed in REQ-012 (unless enabled by REQ-021).
REQ-016 SHALL register the combinational result into o_leds every rising edge, so o_leds reflects register contents with one cycle of latency after the last load edge.
REQ-017 SHALL update o_leds continuously while loading; intermediate results are visible.

Reset
REQ-018 SHALL clear A, OP, B and o_leds to zero immediately when i_reset is low, independent of i_clock.
REQ-019 SHALL ignore i_enable while i_reset is low; a reset mid-load discards the load.
REQ-020 SHALL resume loading on the first rising edge after i_reset returns high.

Configuration
REQ-021 SHALL, when macro ALU_SLL_EN is defined, decode OP 000000 as SLL (A shifted left by B, zero-filled, >= width gives zero); without it, 000000 SHALL output zero.

Structure
REQ-022 SHALL place opcode constants and the default widths in shared package alu_pkg.
REQ-023 SHALL implement the combinational operation in sub-module alu_core (inputs A, B, OP; output result); the top holds the registers.

Verification
REQ-024 SHALL verify: load A=010101, OP=100000, B=010101 -> o_leds=101010; A=110101, B=000101 -> 111010.
REQ-025 SHALL verify: SUB A=010101, B=000101 -> 010000; AND A=110101, B=000101 -> 000101; OR -> 110101; XOR -> 110000; NOR -> 001010.
REQ-026 SHALL verify: A=110101, B=000011, SRA -> 111110; SRL -> 000110.
REQ-027 SHALL verify: OP=111111 with A=110101, B=000101 -> 000000; with ALU_SLL_EN, OP=000000, A=000101, B=000010 -> 010100.
REQ-028 SHALL verify: i_reset low mid-operation -> o_leds=000000 without a clock edge; after release with no loads, o_leds stays 000000.
REQ-029 SHALL verify: i_enable[3] toggled with new i_switch -> registers and o_leds unchanged.
